// File: rtl/stn_lcdc_gen.sv
// STN LCD bus timing generator (lflm/llp/lck/ld) fed by a 4-bit nibble handshake.
// Define STN_LCDC_GEN_PATTERN_EN to replace pix_data with an internal checkerboard pattern.
module stn_lcdc_gen #(
   parameter int WIDTH    = 320,
   parameter int HEIGHT   = 240,
   parameter int CK_DIV   = 2,
   parameter int HBLANK   = 8,
   parameter int LP_WIDTH = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enable,
   input  logic       pix_valid,
   input  logic [3:0] pix_data,
   output logic       pix_ready,
   output logic       lflm,
   output logic       llp,
   output logic       lck,
   output logic [3:0] ld,
   output logic       frame_start,
   output logic       underrun,
   output logic [8:0] line
);

   localparam int NIBS   = WIDTH / 4;
   localparam int PERIOD = 2 * CK_DIV;
   localparam int CMAX   = (PERIOD > HBLANK) ? ((PERIOD > LP_WIDTH) ? PERIOD : LP_WIDTH)
                                             : ((HBLANK > LP_WIDTH) ? HBLANK : LP_WIDTH);
   localparam int CW     = $clog2(CMAX + 1);
   localparam int NW     = $clog2(NIBS + 1);

   localparam logic [CW-1:0] PER_LAST  = CW'(PERIOD - 1);
   localparam logic [CW-1:0] HI_FIRST  = CW'(CK_DIV);
   localparam logic [CW-1:0] HB_LAST   = CW'(HBLANK - 1);
   localparam logic [CW-1:0] LP_LAST   = CW'(LP_WIDTH - 1);
   localparam logic [NW-1:0] NIB_LAST  = NW'(NIBS - 1);
   localparam logic [8:0]    LINE_LAST = 9'(HEIGHT - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_HBLANK, ST_LPULSE} state_t;

   state_t        state, nxt;
   logic [CW-1:0] cnt;
   logic [NW-1:0] nib;
   logic          per_end, data_end, hb_end, lp_end, frame_end, frame_go;
   logic [3:0]    nibble;

   // The panel shifts ld[3] first, so the leftmost pixel lands on ld[3].
   function automatic logic [3:0] bit_rev(input logic [3:0] d);
      return {d[0], d[1], d[2], d[3]};
   endfunction

   always_comb begin
      per_end   = (state == ST_DATA) && (cnt == PER_LAST);
      data_end  = per_end && (nib == NIB_LAST);
      hb_end    = (state == ST_HBLANK) && (cnt == HB_LAST);
      lp_end    = (state == ST_LPULSE) && (cnt == LP_LAST);
      frame_end = lp_end && (line == LINE_LAST);
      frame_go  = ((state == ST_IDLE) || frame_end) && enable;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= nxt;
   end

   // enable is only looked at in IDLE and at the frame boundary.
   always_comb begin
      nxt = state;
      case (state)
         ST_IDLE:   if (enable)   nxt = ST_DATA;
         ST_DATA:   if (data_end) nxt = ST_HBLANK;
         ST_HBLANK: if (hb_end)   nxt = ST_LPULSE;
         ST_LPULSE: if (lp_end)   nxt = (frame_end && !enable) ? ST_IDLE : ST_DATA;
         default:                 nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      pix_ready = (state == ST_DATA) && (cnt == '0);
      lck       = (state == ST_DATA) && (cnt >= HI_FIRST);
      llp       = (state == ST_LPULSE);
      lflm      = llp && (line == LINE_LAST);
   end

`ifdef STN_LCDC_GEN_PATTERN_EN
   logic unused_src;
   assign unused_src = ^{pix_valid, pix_data};

   // column/4 equals the nibble index, so parity of (nib + line) picks the square colour.
   always_comb nibble = {4{nib[0] ^ line[0]}};
`else
   always_comb nibble = pix_valid ? bit_rev(pix_data) : 4'b0000;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt         <= '0;
         nib         <= '0;
         line        <= '0;
         ld          <= 4'b0000;
         frame_start <= 1'b0;
         underrun    <= 1'b0;
      end else begin
         frame_start <= frame_go;

         if ((nxt != state) || per_end || (state == ST_IDLE)) cnt <= '0;
         else                                                 cnt <= cnt + CW'(1);

         if ((state != ST_DATA) || data_end) nib <= '0;
         else if (per_end)                   nib <= nib + NW'(1);

         if (state == ST_IDLE) line <= '0;
         else if (lp_end)      line <= frame_end ? 9'd0 : line + 9'd1;

         // ld holds through blanking; it only returns to 0 when the generator goes idle.
         if (pix_ready)                ld <= nibble;
         else if (frame_end && !enable) ld <= 4'b0000;

`ifndef STN_LCDC_GEN_PATTERN_EN
         if (pix_ready && !pix_valid) underrun <= 1'b1;
`endif
      end
   end

endmodule

// File: tb/tb_stn_lcdc_gen.sv
// Scoreboard bench for stn_lcdc_gen: frame-level timing model plus queued ld expectations.
module tb_stn_lcdc_gen;

   localparam int W         = 16;
   localparam int H         = 4;
   localparam int CKD       = 2;
   localparam int HB        = 4;
   localparam int LPW       = 2;
   localparam int NIB       = W / 4;
   localparam int DATA_CYC  = NIB * 2 * CKD;
   localparam int LINE_CYC  = DATA_CYC + HB + LPW;
   localparam int FRAME_CYC = LINE_CYC * H;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       enable = 1'b0;
   logic       pix_valid = 1'b0;
   logic [3:0] pix_data = 4'b0000;
   logic       pix_ready, lflm, llp, lck, frame_start, underrun;
   logic [3:0] ld;
   logic [8:0] line;

   stn_lcdc_gen #(
      .WIDTH(W), .HEIGHT(H), .CK_DIV(CKD), .HBLANK(HB), .LP_WIDTH(LPW)
   ) dut (
      .clk(clk), .rst(rst), .enable(enable),
      .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
      .lflm(lflm), .llp(llp), .lck(lck), .ld(ld),
      .frame_start(frame_start), .underrun(underrun), .line(line)
   );

   initial forever #5 clk = ~clk;

   // Reference model: position within a frame, frame period FRAME_CYC, enable sampled at the boundary.
   bit         m_act = 1'b0;
   int         m_k   = 0;
   bit         m_ur  = 1'b0;
   int         cyc   = 0;
   logic [3:0] sb[$];
   bit         force01 = 1'b1;
   int         drop_mode = 0;
   int         tmo = 0;
   bit         done = 1'b0;
   int         total = 0;
   int         bad = 0;

   function automatic logic [3:0] rev4(input logic [3:0] d);
      return {d[0], d[1], d[2], d[3]};
   endfunction

   initial forever begin
      @(posedge clk);
      cyc = cyc + 1;
   end

   initial forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
         m_act = 1'b0;
         m_k   = 0;
         m_ur  = 1'b0;
      end else begin
         if (m_act && (m_k % LINE_CYC) < DATA_CYC && ((m_k % LINE_CYC) % (2 * CKD)) == 0 && !pix_valid)
            m_ur = 1'b1;
         if (!m_act) begin
            if (enable) begin m_act = 1'b1; m_k = 0; end
         end else if (m_k == FRAME_CYC - 1) begin
            if (enable) m_k = 0;
            else begin m_act = 1'b0; m_k = 0; end
         end else begin
            m_k = m_k + 1;
         end
      end
   end

   // Driver: issues a nibble in every handshake cycle the model predicts and queues the expected ld.
   initial forever begin
      int         dpos, dln;
      logic [3:0] d;
      bit         v;
      @(posedge clk);
      #1;
      dpos = m_k % LINE_CYC;
      dln  = m_k / LINE_CYC;
      if (m_act && dpos < DATA_CYC && (dpos % (2 * CKD)) == 0) begin
         d = 4'($urandom);
         v = 1'b1;
         if (force01 && dln == 0 && dpos == 0) d = 4'b0001;
         if (drop_mode == 1)      v = !(dln == 1 && dpos / (2 * CKD) == 2);
         else if (drop_mode == 2) v = ($urandom_range(0, 3) != 0);
         pix_data  = d;
         pix_valid = v;
         sb.push_back(v ? rev4(d) : 4'b0000);
      end else begin
         pix_data  = 4'($urandom);
         pix_valid = 1'($urandom);
      end
   end

   task automatic chk(input string nm, input int act, input int exp);
      total = total + 1;
      if (act != exp) begin
         bad = bad + 1;
         $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
      end
   endtask

   // Monitor: per-cycle comparison against the model, scoreboard pop at each rising lck.
   bit prev_lck = 1'b0, prev_llp = 1'b0, prev_rst = 1'b0;
   int rises = 0, last_llp = -1, last_fs = -1;
   int mpos, mln, e_line;
   bit e_data, e_ready, e_lck, e_llp, e_lflm, e_fs;
   logic [3:0] e_ld;

   initial forever begin
      @(negedge clk);
      mpos    = m_k % LINE_CYC;
      mln     = m_k / LINE_CYC;
      e_data  = m_act && mpos < DATA_CYC;
      e_ready = e_data && (mpos % (2 * CKD)) == 0;
      e_lck   = e_data && (mpos % (2 * CKD)) >= CKD;
      e_llp   = m_act && mpos >= DATA_CYC + HB;
      e_lflm  = e_llp && mln == H - 1;
      e_fs    = m_act && m_k == 0;
      e_line  = m_act ? mln : 0;

      if (rst) begin
         sb.delete();
         rises    = 0;
         last_llp = -1;
         last_fs  = -1;
         if (!prev_rst) begin
            chk("rst_lck", lck, 0);
            chk("rst_pix_ready", pix_ready, 0);
            chk("rst_ld", ld, 0);
            chk("rst_line", line, 0);
            chk("rst_underrun", underrun, 0);
         end
      end

      chk("pix_ready", pix_ready, e_ready);
      chk("lck", lck, e_lck);
      chk("llp", llp, e_llp);
      chk("lflm", lflm, e_lflm);
      chk("frame_start", frame_start, e_fs);
      chk("line", line, e_line);
      chk("underrun", underrun, m_ur);
      chk("llp_lck_overlap", llp & lck, 0);
      if (!m_act) chk("idle_ld", ld, 0);

      if (lck && !prev_lck) begin
         rises = rises + 1;
         if (sb.size() == 0) chk("sb_has_entry", sb.size(), 1);
         else begin
            e_ld = sb.pop_front();
            chk("ld_at_lck_rise", ld, e_ld);
         end
      end
      if (llp && !prev_llp) begin
         chk("lck_rises_per_line", rises, NIB);
         rises = 0;
         if (last_llp >= 0) chk("line_period", cyc - last_llp, LINE_CYC);
         last_llp = cyc;
      end
      if (frame_start) begin
         if (last_fs >= 0) chk("frame_period", cyc - last_fs, FRAME_CYC);
         last_fs = cyc;
      end
      if (!m_act) begin
         last_llp = -1;
         last_fs  = -1;
      end

      prev_lck = lck;
      prev_llp = llp;
      prev_rst = rst;

      if (done) begin
         chk("wait_timeouts", tmo, 0);
         chk("sb_drained", sb.size(), 0);
         $display("test done: total=%0d bad=%0d", total, bad);
         $finish;
      end
   end

   task automatic wait_k(input int target, input int budget);
      int n;
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n = n + 1;
      end while (!(m_act && m_k == target) && n < budget);
      if (!(m_act && m_k == target)) tmo = tmo + 1;
   endtask

   task automatic wait_idle(input int budget);
      int n;
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n = n + 1;
      end while (m_act && n < budget);
      if (m_act) tmo = tmo + 1;
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      repeat (4) @(posedge clk);
      #1 enable = 1'b1;

      // Two clean frames back to back.
      wait_k(0, 20);
      wait_k(FRAME_CYC - 1, 200);
      wait_k(0, 5);
      wait_k(FRAME_CYC - 1, 200);
      wait_k(0, 5);

      // Third nibble of line 1 missing.
      drop_mode = 1;
      wait_k(FRAME_CYC - 1, 200);
      wait_k(0, 5);

      // Random gaps in the source.
      drop_mode = 2;
      wait_k(FRAME_CYC - 1, 200);
      wait_k(0, 5);
      drop_mode = 0;

      // Drop enable during line 1: the frame must still complete.
      wait_k(LINE_CYC + 5, 200);
      enable = 1'b0;
      wait_idle(200);
      repeat (20) @(posedge clk);
      #1 enable = 1'b1;

      // Reset in the middle of a DATA phase, then restart.
      wait_k(2 * LINE_CYC + 6, 300);
      #1 rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      wait_k(0, 10);
      wait_k(FRAME_CYC - 1, 200);
      enable = 1'b0;
      wait_idle(20);
      repeat (5) @(posedge clk);
      #1 done = 1'b1;
      repeat (20) @(posedge clk);
      $display("FAIL monitor_finish: monitor never reached summary");
      $fatal(1);
   end

endmodule

// File: doc/stn_lcdc_gen.md
STN_LCDC_GEN -- requirements
Module: stn_lcdc_gen

Interface
REQ-001 SHALL have parameter WIDTH, default 320, pixels per line, a multiple of 4 and at most 1020.
REQ-002 SHALL have parameter HEIGHT, default 240, lines per frame, from 2 to 511.
REQ-003 SHALL have parameter CK_DIV, default 2, clk cycles per lck half-period, at least 1.
REQ-004 SHALL have parameters HBLANK, default 8, and LP_WIDTH, default 2, both in clk cycles and both at least 1.
REQ-005 SHALL have port clk, input, 1 bit, the single system clock.
REQ-006 SHALL have port rst, input, 1 bit, asynchronous active-high reset.
REQ-007 SHALL have port enable, input, 1 bit, which starts and continues frame generation.
REQ-008 SHALL have ports pix_valid (input, 1), pix_data (input, 4) and pix_ready (output, 1), the nibble source handshake; pix_data[0] is the leftmost pixel.
REQ-009 SHALL have ports lflm, llp, lck (outputs, 1 bit each) and ld (output, 4 bits), the STN LCD bus as driven by the DragonBall LCDC.
REQ-010 SHALL have ports frame_start (output, 1), underrun (output, 1) and line (output, 9), the status outputs.

Function
REQ-011 SHALL implement the states IDLE, DATA, HBLANK and LPULSE.
REQ-012 SHALL go from IDLE to DATA on the first clk with enable=1, with line=0 and a one-cycle frame_start pulse.
REQ-013 In DATA, SHALL emit WIDTH/4 lck periods; each period is CK_DIV cycles low then CK_DIV cycles high, starting low.
REQ-014 At the first clk of each lck low phase, SHALL assert pix_ready for exactly one cycle.
REQ-015 On the next clk, SHALL load ld from pix_data with bit reversal (ld[3]=pix_data[0], ld[0]=pix_data[3]); ld then holds stable through the following rising lck edge.
REQ-016 If pix_valid=0 during the pix_ready cycle, SHALL load ld=4'b0000, set sticky underrun, and keep lck timing unchanged (no stall).
REQ-017 After the last lck high phase, SHALL hold lck low and enter HBLANK for HBLANK cycles, keeping ld at its last value.
REQ-018 In LPULSE, SHALL drive llp=1 for LP_WIDTH cycles while keeping lck=0.
REQ-019 SHALL drive lflm=1 for exactly the same cycles as llp during the LPULSE that ends line HEIGHT-1, and lflm=0 at all other times.
REQ-020 On leaving LPULSE, SHALL increment line, or wrap it to 0 after HEIGHT-1.
REQ-021 On wrap, SHALL enter DATA with a frame_start pulse if enable=1, else enter IDLE.
REQ-022 SHALL sample enable only at the frame boundary; deasserting it mid-frame completes the current frame.
REQ-023 Line period SHALL be (WIDTH/4)*2*CK_DIV + HBLANK + LP_WIDTH clk cycles; frame period SHALL be HEIGHT line periods with no gaps.
REQ-024 SHALL keep pix_ready=0 outside DATA and SHALL never assert llp and lck together.

Reset
REQ-025 While rst=1, SHALL immediately force lflm, llp, lck, ld, pix_ready, frame_start, underrun and line to 0 and the state to IDLE, including mid-line.
REQ-026 After rst falls, SHALL start in IDLE and restart from line 0 when enable=1, with no partial frame.
REQ-027 SHALL clear underrun only by reset.

Configuration
REQ-028 With STN_LCDC_GEN_PATTERN_EN defined, SHALL take the nibble in each pix_ready cycle from an internal pattern rather than pix_data: the nibble is 4'b1111 when (column/4 + line) is odd, else 4'b0000, where column is the index of the nibble's first pixel within the line. In this mode pix_valid is ignored and underrun stays 0.
REQ-029 Without STN_LCDC_GEN_PATTERN_EN, SHALL take data from pix_data only and SHALL contain no pattern logic.

Verification (WIDTH=16, HEIGHT=4, CK_DIV=2, HBLANK=4, LP_WIDTH=2)
REQ-030 Bench SHALL check that enable=1 with pix_valid=1 gives 4 lck rising edges per line, a line period of 22 clk cycles, a frame period of 88, and frame_start every 88 cycles.
REQ-031 Bench SHALL check that pix_data=4'b0001 drives ld=4'b1000 at the next rising lck edge.
REQ-032 Bench SHALL check that pix_valid=0 for the 3rd nibble of line 1 gives ld=0 for that lck period, underrun=1 staying set, and unchanged lck timing.
REQ-033 Bench SHALL check that lflm=1 only during the 2-cycle llp after line 3, and that line then reads 0.
REQ-034 Bench SHALL check that dropping enable during line 1 gives a complete frame through line 3's LPULSE, then IDLE with all outputs 0.
REQ-035 Bench SHALL check that rst asserted mid-DATA drops all outputs to 0 within the same cycle, and that the frame restarts at line 0 after release.
